fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Sits directly upstream of the instruction ROM, which has a
//  1-cycle registered read. Generates the PC and drives the ROM word address. Pairs each
//  returned word with its PC and presents {pc, inst} to decode over a valid/ready handshake.
//  Handles redirects (branch/jump) by squashing the in-flight read and flushing buffered words.
// PARAMETERS
//  XLEN        32  PC and instruction width
//  ADDR_W      4   ROM word-address width (ROM depth = 2**ADDR_W)
//  RESET_PC    0   byte PC loaded at reset
//  BUF_DEPTH   2   output buffer entries; >=2 required for 1 instr/cycle throughput
// PORTS
//  CLK             in   1       clock; all state updates on posedge
//  RST_N           in   1       synchronous reset, active-low
//  mem_addr        out  ADDR_W  ROM word address; combinational; ROM returns data next cycle
//  mem_data        in   XLEN    ROM read data for the address presented the previous cycle
//  redirect_valid  in   1       load a new PC this cycle
//  redirect_pc     in   XLEN    target byte PC; bits [1:0] ignored (treated as 0)
//  out_valid       out  1       {out_pc, out_inst} holds a valid instruction
//  out_ready       in   1       decode accepts; transfer when out_valid && out_ready
//  out_pc          out  XLEN    byte PC of out_inst
//  out_inst        out  XLEN    instruction word
// BEHAVIOUR
//  - Reset (RST_N=0 at posedge): pc_q=RESET_PC, buffer count=0, inflight=0, squash=0.
//    out_valid=0, out_pc=0, out_inst=0 while empty. mem_addr = RESET_PC[ADDR_W+1:2].
//  - mem_addr = redirect_valid ? redirect_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2].
//  - Issue rule (cycle N): issue = RST_N && (count + inflight - pop) < BUF_DEPTH,
//    pop = out_valid && out_ready. On issue: inflight<=1, req_pc<=issued PC,
//    pc_q<=issued PC+4 (mod 2**XLEN). No issue: inflight<=0, pc_q holds.
//  - Return (cycle N+1): if inflight && !squash && !redirect_valid, push {req_pc, mem_data}.
//    Latency: issue N -> out_valid N+2 when the buffer is empty.
//  - Buffer: in-order FIFO. Simultaneous push and pop are allowed when full; count unchanged.
//    Push never occurs when count==BUF_DEPTH (guaranteed by issue rule). Violation is an assertion failure.
//  - Backpressure: while out_ready=0, out_pc/out_inst/out_valid stay stable. No loss or duplication.
//  - Redirect (cycle R): buffer flushed (count<=0). out_valid forced 0 in cycle R, so no transfer
//    occurs in R. The read issued in R-1 is squashed. The target is issued in R (pc_q<=target+4),
//    and out_valid rises in R+2 with out_pc=target. Back-to-back redirects: the last one wins.
//  - PC wraps modulo 2**XLEN. The ROM index wraps naturally (word 2**ADDR_W-1 -> 0).
//  - Reset mid-operation discards all in-flight and buffered state. The next cycle behaves as cold reset.
// STRUCTURE
//  - Shared package/defines: XLEN, ILEN, RESET_PC, NOP encoding, fetch-entry field widths.
//  - Sub-module fetch_buffer: parameterised sync FIFO (push/pop/flush, count).
//  - Top: PC register, inflight/squash flags, issue logic.
// TESTING (bench ROM preloaded: word i = 32'h1000_0000 + i)
//  1. RST_N=0 for 3 cycles, out_ready=1 -> out_valid=0, mem_addr=0; release at cycle T ->
//     out_valid=1 at T+2 with out_pc=0, out_inst=32'h1000_0000.
//  2. out_ready=1 for 20 outputs -> one transfer/cycle, pc 0,4,..,0x3C,0x40; pc 0x40 carries
//     inst 32'h1000_0000 (index wrap).
//  3. Mid-stream out_ready=0 for 5 cycles -> outputs frozen. After release, the sequence
//     continues with the next PC, no gaps or repeats.
//  4. Buffer full + read in flight, redirect_pc=0x20 at R -> out_valid=0 at R and R+1;
//     R+2 out_pc=0x20, inst 32'h1000_0008; then 0x24, 0x28...
//  5. Redirects at R (0x10) and R+1 (0x30), out_ready=1 -> no 0x10 output; R+3 out_pc=0x30.
//  6. RST_N=0 for one cycle with the buffer full -> next cycle out_valid=0; first output is
//     pc=RESET_PC two cycles after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and defaults.
// The fetch entry pairs a byte PC with its instruction word.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_BUF_DEPTH = 2;
  localparam logic [XLEN-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// In-order fetch buffer: sync FIFO with push, pop and flush.
// Flush wins over push/pop; push+pop when full keeps count.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEF_BUF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  fetch_entry_t    i_wdata,
  output fetch_entry_t    o_rdata,
  output logic [CW-1:0]   o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  assign o_rdata = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      end
      if (i_pop) begin
        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && !i_flush && r_count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, 1-cycle ROM read tracking, redirect squash,
// and an output buffer sized so the ROM never returns into a full FIFO.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ILEN-1:0]   mem_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_inst
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_pc;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  fetch_entry_t    w_head;
  fetch_entry_t    w_new;

  assign w_tgt    = redirect_pc & ~XLEN'(3);
  assign w_pc     = redirect_valid ? w_tgt : r_pc;
  assign mem_addr = w_pc[ADDR_W+1:2];

  assign w_empty   = (w_count == '0);
  assign out_valid = !w_empty && !redirect_valid;
  assign out_pc    = w_empty ? '0 : w_head.pc;
  assign out_inst  = w_empty ? '0 : w_head.inst;
  assign w_pop     = out_valid && out_ready;

  // A redirect flushes the buffer and kills the returning read, so it always issues.
  assign w_occ = redirect_valid ? '0
               : ({1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop));
  assign w_issue = RST_N && (w_occ < (CW+1)'(BUF_DEPTH));

  assign w_push    = r_inflight && !redirect_valid;
  assign w_new.pc   = r_req_pc;
  assign w_new.inst = mem_data;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_pc;
        r_pc     <= w_pc + XLEN'(4);
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_new),
    .o_rdata (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-while-full sequence,
// then random ready/redirect traffic against a PC-stream reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= 32'h1000_0000 + 32'(mem_addr);

  fetch_unit dut (
    .CLK            (clk),
    .RST_N          (RST_N),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic        cd;
    logic [31:0] epc;
    logic        ca;
    logic [3:0]  ea;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] rom_of(input logic [31:0] pc);
    return 32'h1000_0000 + 32'(pc[5:2]);
  endfunction

  function automatic void add(input logic rst, rdy, rv, input logic [31:0] rpc,
                              input logic ev, cd, input logic [31:0] epc,
                              input logic ca, input logic [3:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.cd = cd; v.epc = epc; v.ca = ca; v.ea = ea;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rdy, rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    RST_N = rst;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  logic [31:0] exp_pc;
  int          since;
  logic        rdy;
  logic        rv;
  logic [31:0] rpc;

  initial begin
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 1, 1);
    for (int k = 0; k < 20; k++) add(1, 1, 0, 0, 1, 1, 32'(4 * k), 1, 4'((k + 2) % 16));
    for (int j = 0; j < 5; j++) add(1, 0, 0, 0, 1, 1, 32'h50, 0, 0);
    for (int j = 0; j < 3; j++) add(1, 1, 0, 0, 1, 1, 32'h50 + 32'(4 * j), 0, 0);
    for (int j = 0; j < 3; j++) add(1, 0, 0, 0, 1, 1, 32'h5C, 0, 0);
    add(1, 1, 1, 32'h22, 0, 0, 0, 1, 8);
    add(1, 1, 0, 0, 0, 1, 0, 1, 9);
    for (int j = 0; j < 3; j++) add(1, 1, 0, 0, 1, 1, 32'h20 + 32'(4 * j), 1, 4'(10 + j));
    add(1, 1, 1, 32'h10, 0, 0, 0, 1, 4);
    add(1, 1, 1, 32'h30, 0, 0, 0, 1, 12);
    add(1, 1, 0, 0, 0, 1, 0, 1, 13);
    add(1, 1, 0, 0, 1, 1, 32'h30, 1, 14);
    add(1, 1, 0, 0, 1, 1, 32'h34, 1, 15);
    add(1, 1, 0, 0, 1, 1, 32'h38, 1, 0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].rdy, vt[i].rv, vt[i].rpc);
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vt[i].ev));
      if (vt[i].cd) begin
        chk($sformatf("vec%0d.pc", i), out_pc, vt[i].ev ? vt[i].epc : 32'h0);
        chk($sformatf("vec%0d.inst", i), out_inst, vt[i].ev ? rom_of(vt[i].epc) : 32'h0);
      end
      if (vt[i].ca) chk($sformatf("vec%0d.addr", i), 32'(mem_addr), 32'(vt[i].ea));
    end

    // Fill the buffer under backpressure, then pulse reset for one cycle.
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 0, 0);
      chk("bp.pc", out_pc, 32'h3C);
    end
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    chk("rst1.valid", 32'(out_valid), 32'h0);
    chk("rst1.addr", 32'(mem_addr), 32'h0);
    chk("rst1.pc", out_pc, 32'h0);
    drive(1, 1, 0, 0);
    chk("rst2.valid", 32'(out_valid), 32'h0);
    drive(1, 1, 0, 0);
    chk("rst3.valid", 32'(out_valid), 32'h1);
    chk("rst3.pc", out_pc, 32'h0);
    chk("rst3.inst", out_inst, 32'h1000_0000);

    // Reference: outputs form a gap-free +4 stream from the last redirect target.
    exp_pc = 32'h4;
    since = 2;
    for (int c = 0; c < 500; c++) begin
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(11) == 0);
      rpc = ($urandom_range(1) == 1) ? $urandom : (32'hFFFF_FFC0 | 32'($urandom_range(63)));
      drive(1, rdy, rv, rpc);
      if (rv) begin
        chk("rnd.rv_valid", 32'(out_valid), 32'h0);
        chk("rnd.rv_addr", 32'(mem_addr), 32'(rpc[5:2]));
        exp_pc = {rpc[31:2], 2'b00};
        since = 0;
      end else begin
        since++;
        if (since == 1) begin
          chk("rnd.bubble", 32'(out_valid), 32'h0);
        end else begin
          chk("rnd.valid", 32'(out_valid), 32'h1);
          chk("rnd.pc", out_pc, exp_pc);
          chk("rnd.inst", out_inst, rom_of(exp_pc));
          if (rdy) exp_pc = exp_pc + 32'h4;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
